bias_activation: RTL and testbench



---
 rtl/nn_pkg.sv | 19 +
 rtl/sat_add_act.sv | 32 +++
 rtl/bias_activation.sv | 152 +++++++++++++++
 tb/tb_bias_activation.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared types for the neural-network datapath layers.
//   word_t       : signed 32-bit datapath word
//   WORD_MAX/MIN : saturation limits of word_t
//   act_e        : activation select
package nn_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic signed [WORD_W-1:0] word_t;

    localparam word_t WORD_MAX = word_t'(32'h7FFF_FFFF);
    localparam word_t WORD_MIN = word_t'(32'h8000_0000);

    typedef enum logic [0:0] {
        ACT_IDENTITY = 1'b0,
        ACT_RELU     = 1'b1
    } act_e;

endpackage

// File: rtl/sat_add_act.sv
// Saturating signed add followed by the selected activation (combinational).
//   a, b : signed operands
//   y_c  : activation(saturate(a + b))
module sat_add_act
    import nn_pkg::*;
#(
    parameter act_e ACT = ACT_RELU
) (
    input  word_t a,
    input  word_t b,
    output word_t y_c
);

    logic [WORD_W:0] sum_c;
    word_t           sat_c;

    // 33-bit sum; top two bits disagree exactly when the 32-bit result overflowed
    always_comb begin
        sum_c = {a[WORD_W-1], a} + {b[WORD_W-1], b};
        if (sum_c[WORD_W] != sum_c[WORD_W-1]) begin
            sat_c = sum_c[WORD_W] ? WORD_MIN : WORD_MAX;
        end else begin
            sat_c = sum_c[WORD_W-1:0];
        end
        if ((ACT == ACT_RELU) && sat_c[WORD_W-1]) begin
            y_c = '0;
        end else begin
            y_c = sat_c;
        end
    end

endmodule

// File: rtl/bias_activation.sv
// Serial bias-add + activation stage for one fully connected layer.
//   clk, rst (async, active-low)
//   enable   : level start, held for the whole pass
//   data_in  : linear-layer products [COUNT][OUTPUT_SIZE]
//   biases   : per-element bias [COUNT][OUTPUT_SIZE]
//   data_out : registered results, written one element per RUN cycle
//   busy     : high while in RUN
//   done     : pass complete, held until enable falls
module bias_activation
    import nn_pkg::*;
#(
    parameter int unsigned COUNT       = 1,
    parameter int unsigned OUTPUT_SIZE = 4,
    parameter int unsigned ACT         = 1
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  enable,
    input  word_t data_in  [COUNT][OUTPUT_SIZE],
    input  word_t biases   [COUNT][OUTPUT_SIZE],
    output word_t data_out [COUNT][OUTPUT_SIZE],
    output logic  busy,
    output logic  done
);

    localparam int unsigned N  = COUNT * OUTPUT_SIZE;
    localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned RW = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam int unsigned CW = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1;
    localparam act_e ACT_SEL   = (ACT == 1) ? ACT_RELU : ACT_IDENTITY;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [RW-1:0]   row_q, row_d;
    logic [CW-1:0]   col_q, col_d;
    logic            busy_d, done_d;
    logic            we_c;
    word_t           a_c, b_c, res_c;

    // Next-state: row/col track k in row-major order so no divider is needed
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        row_d   = row_q;
        col_d   = col_q;
        we_c    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_RUN;
                    k_d     = '0;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            S_RUN: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else begin
                    we_c = 1'b1;
                    if (k_q == KW'(N - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        k_d = k_q + KW'(1);
                        if (col_q == CW'(OUTPUT_SIZE - 1)) begin
                            col_d = '0;
                            row_d = row_q + RW'(1);
                        end else begin
                            col_d = col_q + CW'(1);
                        end
                    end
                end
            end
            S_DONE: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_RUN);
        // done lags the DONE entry by one edge and drops on the first low enable
        done_d = (state_q == S_DONE) && enable;
    end

    // Operand select for the current element
    always_comb begin
        a_c = '0;
        b_c = '0;
        for (int r = 0; r < int'(COUNT); r++) begin
            for (int c = 0; c < int'(OUTPUT_SIZE); c++) begin
                if ((row_q == RW'(r)) && (col_q == CW'(c))) begin
                    a_c = data_in[r][c];
                    b_c = biases[r][c];
                end
            end
        end
    end

    sat_add_act #(
        .ACT (ACT_SEL)
    ) u_sat_add_act (
        .a   (a_c),
        .b   (b_c),
        .y_c (res_c)
    );

    // State, index and status registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            row_q   <= '0;
            col_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            row_q   <= row_d;
            col_q   <= col_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    // Output array: only the current element is written, others hold
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < int'(COUNT); r++) begin
                for (int c = 0; c < int'(OUTPUT_SIZE); c++) begin
                    data_out[r][c] <= '0;
                end
            end
        end else if (we_c) begin
            for (int r = 0; r < int'(COUNT); r++) begin
                for (int c = 0; c < int'(OUTPUT_SIZE); c++) begin
                    if ((row_q == RW'(r)) && (col_q == CW'(c))) begin
                        data_out[r][c] <= res_c;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_bias_activation.sv
// Directed bench for bias_activation: three instances cover ReLU 1x4,
// identity saturation 1x3 and row-major ordering 2x3.
module tb_bias_activation;
    import nn_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ReLU 1x4
    logic  en_a = 1'b0;
    word_t din_a  [1][4];
    word_t bias_a [1][4];
    word_t dout_a [1][4];
    logic  busy_a, done_a;

    // identity 1x3 (saturation)
    logic  en_b = 1'b0;
    word_t din_b  [1][3];
    word_t bias_b [1][3];
    word_t dout_b [1][3];
    logic  busy_b, done_b;

    // identity 2x3 (ordering)
    logic  en_c = 1'b0;
    word_t din_c  [2][3];
    word_t bias_c [2][3];
    word_t dout_c [2][3];
    logic  busy_c, done_c;

    bias_activation #(.COUNT(1), .OUTPUT_SIZE(4), .ACT(1)) u_relu (
        .clk(clk), .rst(rst), .enable(en_a), .data_in(din_a), .biases(bias_a),
        .data_out(dout_a), .busy(busy_a), .done(done_a)
    );

    bias_activation #(.COUNT(1), .OUTPUT_SIZE(3), .ACT(0)) u_sat (
        .clk(clk), .rst(rst), .enable(en_b), .data_in(din_b), .biases(bias_b),
        .data_out(dout_b), .busy(busy_b), .done(done_b)
    );

    bias_activation #(.COUNT(2), .OUTPUT_SIZE(3), .ACT(0)) u_grid (
        .clk(clk), .rst(rst), .enable(en_c), .data_in(din_c), .biases(bias_c),
        .data_out(dout_c), .busy(busy_c), .done(done_c)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int n_busy;
    int done_at;
    logic held;

    initial begin
        din_a  = '{'{32'sd5, -32'sd3, 32'sd10, 32'sd0}};
        bias_a = '{'{32'sd1, 32'sd1, -32'sd20, 32'sd0}};
        din_b  = '{'{word_t'(32'h7FFF_FFF0), word_t'(32'h8000_0005), -32'sd7}};
        bias_b = '{'{32'sd32, -32'sd16, 32'sd2}};
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 3; c++) begin
                din_c[r][c]  = word_t'(10 * r + c);
                bias_c[r][c] = 32'sd100;
            end
        end

        // reset state
        #1;
        check("rst_dout_a0", dout_a[0][0], 32'h0);
        check("rst_dout_a3", dout_a[0][3], 32'h0);
        check("rst_busy_a", {31'b0, busy_a}, 32'h0);
        check("rst_done_a", {31'b0, done_a}, 32'h0);
        step();
        rst = 1'b1;
        step();

        // ReLU pass: latency and busy width
        en_a = 1'b1;
        n_busy  = 0;
        done_at = -1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (busy_a) n_busy++;
            if (i == 1) check("relu_el0_first", dout_a[0][0], 32'd6);
            if (done_a) begin
                done_at = i;
                break;
            end
        end
        check("relu_busy_cycles", n_busy, 32'd4);
        check("relu_done_edge", done_at, 32'd5);
        check("relu_out0", dout_a[0][0], 32'd6);
        check("relu_out1", dout_a[0][1], 32'd0);
        check("relu_out2", dout_a[0][2], 32'd0);
        check("relu_out3", dout_a[0][3], 32'd0);

        // hold enable after done with different inputs: nothing rewritten
        din_a  = '{'{32'sd99, 32'sd99, 32'sd99, 32'sd99}};
        held = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (!done_a || busy_a) held = 1'b0;
        end
        check("hold_done", {31'b0, held}, 32'h1);
        check("hold_out0", dout_a[0][0], 32'd6);
        check("hold_out2", dout_a[0][2], 32'd0);
        en_a = 1'b0;
        step();
        check("done_fall", {31'b0, done_a}, 32'h0);

        // abort after the 2nd RUN cycle
        din_a  = '{'{32'sd1, 32'sd2, 32'sd3, 32'sd4}};
        bias_a = '{'{32'sd0, 32'sd0, 32'sd0, 32'sd0}};
        en_a = 1'b1;
        step();
        step();
        step();
        en_a = 1'b0;
        step();
        check("abort_busy", {31'b0, busy_a}, 32'h0);
        held = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (done_a) held = 1'b1;
        end
        check("abort_no_done", {31'b0, held}, 32'h0);
        check("abort_out0", dout_a[0][0], 32'd1);
        check("abort_out1", dout_a[0][1], 32'd2);
        check("abort_out2", dout_a[0][2], 32'd0);
        check("abort_out3", dout_a[0][3], 32'd0);

        // restart runs the full pass
        en_a = 1'b1;
        for (int i = 0; i < 20 && !done_a; i++) step();
        check("rerun_done", {31'b0, done_a}, 32'h1);
        check("rerun_out2", dout_a[0][2], 32'd3);
        check("rerun_out3", dout_a[0][3], 32'd4);
        en_a = 1'b0;
        step();

        // saturation, identity
        en_b = 1'b1;
        for (int i = 0; i < 20 && !done_b; i++) step();
        check("sat_done", {31'b0, done_b}, 32'h1);
        check("sat_pos", dout_b[0][0], 32'h7FFF_FFFF);
        check("sat_neg", dout_b[0][1], 32'h8000_0000);
        check("ident_neg", dout_b[0][2], 32'hFFFF_FFFB);
        en_b = 1'b0;
        step();

        // row-major ordering on 2x3
        en_c = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            if (i == 3) begin
                check("grid_0_2_early", dout_c[0][2], 32'd102);
                check("grid_1_0_notyet", dout_c[1][0], 32'd0);
            end
            if (i == 5) check("grid_1_2_notyet", dout_c[1][2], 32'd0);
            if (i == 6) check("grid_1_2_at6", dout_c[1][2], 32'd112);
        end
        for (int i = 0; i < 20 && !done_c; i++) step();
        check("grid_done", {31'b0, done_c}, 32'h1);
        check("grid_0_0", dout_c[0][0], 32'd100);
        check("grid_0_1", dout_c[0][1], 32'd101);
        check("grid_1_0", dout_c[1][0], 32'd110);
        check("grid_1_1", dout_c[1][1], 32'd111);
        en_c = 1'b0;
        step();

        // async reset mid-RUN
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 3; c++) bias_c[r][c] = 32'sd50;
        end
        en_c = 1'b1;
        step();
        step();
        step();
        check("pre_rst_busy", {31'b0, busy_c}, 32'h1);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_busy", {31'b0, busy_c}, 32'h0);
        check("mid_rst_done", {31'b0, done_c}, 32'h0);
        check("mid_rst_c00", dout_c[0][0], 32'h0);
        check("mid_rst_c11", dout_c[1][1], 32'h0);
        check("mid_rst_c12", dout_c[1][2], 32'h0);
        check("mid_rst_a3", dout_a[0][3], 32'h0);
        en_c = 1'b0;
        step();
        rst = 1'b1;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
